// File: rtl/fifo_word_packer_pkg.sv
// Shared constants for the byte FIFO and its consumers.
// Provides FIFO geometry and a constant clog2 helper.
package fifo_word_packer_pkg;

  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_ADDR_WIDTH = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from the byte FIFO and packs BYTES of them little-endian
// into one word on a valid/ready port; drain flushes a partial word.
// Ports: clk, reset (async, low), fifo_fillcount/fifo_data in,
//        fifo_get out, drain in, out_data/out_nbytes/out_valid out,
//        out_ready in.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int BYTES      = 4,
  parameter int CNT_W      = clog2(BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH:0]    fifo_fillcount,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_get,
  input  logic                   drain,
  output logic [WIDTH*BYTES-1:0] out_data,
  output logic [CNT_W-1:0]       out_nbytes,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(BYTES);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W:0]   LP_CAP  = (CNT_W + 1)'(BYTES);

  logic                   r_get_q;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [WIDTH*BYTES-1:0] r_asm;
  logic [WIDTH*BYTES-1:0] r_out_data;
  logic [CNT_W-1:0]       r_out_nbytes;
  logic                   r_out_valid;

  logic                   w_out_free;
  logic                   w_complete;
  logic                   w_held;
  logic                   w_xfer_cmp;
  logic                   w_xfer_held;
  logic                   w_drain;
  logic [CNT_W:0]         w_inflight;
  logic [WIDTH*BYTES-1:0] w_asm_nxt;

  assign w_out_free  = !r_out_valid || out_ready;
  assign w_complete  = r_get_q && (r_byte_cnt == LP_LAST);
  assign w_held      = (r_byte_cnt == LP_FULL);
  assign w_xfer_cmp  = w_complete && w_out_free;
  assign w_xfer_held = w_held && w_out_free;

  assign w_drain = drain && (fifo_fillcount == '0) && !r_get_q
                && (r_byte_cnt != '0) && !w_held && w_out_free;

  // Bytes already owned: captured plus the one arriving this cycle.
  assign w_inflight = {1'b0, r_byte_cnt} + (CNT_W + 1)'(r_get_q);

  // Empty flag lags occupancy, so only fillcount gates pops.
  assign fifo_get = reset && (fifo_fillcount != '0) && !w_drain
                 && ((w_inflight < LP_CAP) || w_xfer_cmp || w_xfer_held);

  always_comb begin
    w_asm_nxt = r_asm;
    if (r_get_q) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_byte_cnt == CNT_W'(i)) begin
          w_asm_nxt[i*WIDTH +: WIDTH] = fifo_data;
        end
      end
    end
  end

  // Assembly is cleared whenever it is handed off, so partial
  // words drained later always carry zero upper bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_get_q    <= 1'b0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else begin
      r_get_q <= fifo_get;
      if (w_xfer_cmp) begin
        r_asm      <= '0;
        r_byte_cnt <= '0;
      end else if (r_get_q) begin
        r_asm      <= w_asm_nxt;
        r_byte_cnt <= w_complete ? LP_FULL
                                 : r_byte_cnt + CNT_W'(1);
      end else if (w_xfer_held || w_drain) begin
        r_asm      <= '0;
        r_byte_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data   <= '0;
      r_out_nbytes <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      unique case (1'b1)
        w_xfer_cmp: begin
          r_out_data   <= w_asm_nxt;
          r_out_nbytes <= LP_FULL;
          r_out_valid  <= 1'b1;
        end
        w_xfer_held: begin
          r_out_data   <= r_asm;
          r_out_nbytes <= LP_FULL;
          r_out_valid  <= 1'b1;
        end
        w_drain: begin
          r_out_data   <= r_asm;
          r_out_nbytes <= r_byte_cnt;
          r_out_valid  <= 1'b1;
        end
        default: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_nbytes = r_out_nbytes;
  assign out_valid  = r_out_valid;

  // A held full word must never have another byte arriving.
  a_no_overrun: assert property (
    @(posedge clk) disable iff (!reset)
    !(r_get_q && w_held)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO model.
// Table vectors plus sequences for stream, stall, drain and reset.
module tb_fifo_word_packer;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int B  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [AW:0]     fifo_fillcount;
  logic [W-1:0]    fifo_data = '0;
  logic            fifo_get;
  logic            drain = 1'b0;
  logic [W*B-1:0]  out_data;
  logic [CW-1:0]   out_nbytes;
  logic            out_valid;
  logic            out_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_word_packer dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_fillcount (fifo_fillcount),
    .fifo_data      (fifo_data),
    .fifo_get       (fifo_get),
    .drain          (drain),
    .out_data       (out_data),
    .out_nbytes     (out_nbytes),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int head = 0;
  int tail = 0;

  always_comb begin
    fifo_fillcount = (tail - head > 8) ? 4'd8 : 4'(tail - head);
  end

  always @(posedge clk) begin
    if (fifo_get) begin
      fifo_data <= mem[head[7:0]];
      head      <= head + 1;
    end
  end

  logic [31:0] rx_d [0:63];
  logic [2:0]  rx_n [0:63];
  int rx_cnt = 0;

  always @(posedge clk) begin
    if (reset && out_valid && out_ready) begin
      rx_d[rx_cnt[5:0]] <= out_data;
      rx_n[rx_cnt[5:0]] <= out_nbytes;
      rx_cnt            <= rx_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] din;
    int          n;
    bit          drn;
    logic [31:0] exp_d;
    logic [2:0]  exp_n;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[tail[7:0]] = v;
    tail = tail + 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, bad, first, last, ng, fv;
    bit ok;

    tbl[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 3'd4};
    tbl[1] = '{32'h00A3A2A1, 3, 1'b1, 32'h00A3A2A1, 3'd3};
    tbl[2] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 3'd1};
    tbl[3] = '{32'h0000FF00, 2, 1'b1, 32'h0000FF00, 3'd2};
    tbl[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 3'd4};

    // Reset state
    cyc(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_nbytes", out_nbytes, 0);
    chk("rst_data", out_data, 0);
    chk("rst_get", fifo_get, 0);
    reset = 1'b1;
    cyc(2);

    // Empty FIFO: nothing popped, nothing emitted
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (fifo_get || out_valid) bad++;
      cyc(1);
    end
    chk("empty_idle", bad, 0);

    // Streaming at one byte per cycle
    out_ready = 1'b1;
    base = rx_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i * 17));
    #1;
    first = -1; last = -1; ng = 0; fv = -1;
    for (int i = 0; i < 20; i++) begin
      if (fifo_get) begin
        ng++;
        if (first < 0) first = i;
        last = i;
      end
      if (out_valid && fv < 0) fv = i;
      cyc(1);
    end
    chk("stream_first_get", first, 0);
    chk("stream_get_cnt", ng, 8);
    chk("stream_last_get", last, 7);
    chk("stream_latency", fv, 5);
    chk("stream_words", rx_cnt - base, 2);
    chk("stream_w0", rx_d[base], 32'h44332211);
    chk("stream_n0", rx_n[base], 4);
    chk("stream_w1", rx_d[base+1], 32'h88776655);

    // Backpressure: one word held in output, one in assembly
    out_ready = 1'b0;
    base = rx_cnt;
    for (int i = 1; i <= 12; i++) push(8'(i));
    #1;
    cyc(20);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'h04030201);
    chk("bp_nbytes", out_nbytes, 4);
    chk("bp_get", fifo_get, 0);
    chk("bp_fill", fifo_fillcount, 4);
    cyc(5);
    chk("bp_stable", out_data, 32'h04030201);
    out_ready = 1'b1;
    cyc(20);
    chk("bp_words", rx_cnt - base, 3);
    chk("bp_w0", rx_d[base], 32'h04030201);
    chk("bp_w1", rx_d[base+1], 32'h08070605);
    chk("bp_w2", rx_d[base+2], 32'h0C0B0A09);
    chk("bp_fill_end", fifo_fillcount, 0);
    out_ready = 1'b0;
    cyc(2);

    // Table vectors, partial words flushed with drain
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        push(tbl[k].din[8*j +: 8]);
      end
      drain = tbl[k].drn;
      #1;
      wait_valid(40, ok);
      chk("tbl_valid", ok, 1);
      chk("tbl_data", out_data, tbl[k].exp_d);
      chk("tbl_nbytes", out_nbytes, tbl[k].exp_n);
      cyc(1);
      chk("tbl_hold", out_data, tbl[k].exp_d);
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      drain = 1'b0;
      #1;
      chk("tbl_consumed", out_valid, 0);
      cyc(2);
    end

    // Drain with nothing assembled
    drain = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) bad++;
      cyc(1);
    end
    chk("drain_empty", bad, 0);
    drain = 1'b0;

    // Occupancy gap in the middle of a word
    out_ready = 1'b1;
    base = rx_cnt;
    push(8'hA1);
    push(8'hB2);
    cyc(10);
    chk("gap_no_word", out_valid, 0);
    push(8'hC3);
    cyc(3);
    push(8'hD4);
    cyc(10);
    chk("gap_words", rx_cnt - base, 1);
    chk("gap_w0", rx_d[base], 32'hD4C3B2A1);
    chk("gap_n0", rx_n[base], 4);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    cyc(15);
    chk("mr_pre_valid", out_valid, 1);
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    #1;
    chk("mr_pre_get", fifo_get, 1);
    reset = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_nbytes", out_nbytes, 0);
    chk("mr_data", out_data, 0);
    chk("mr_get", fifo_get, 0);
    cyc(3);
    chk("mr_get_hold", fifo_get, 0);
    chk("mr_fill", fifo_fillcount, 4);
    reset = 1'b1;
    base = rx_cnt;
    out_ready = 1'b1;
    cyc(15);
    chk("mr_words", rx_cnt - base, 1);
    chk("mr_w0", rx_d[base], 32'h34333231);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
